// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the L1 system-bus memory responder.
package sys_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RDISSUE,
    RDLAST,
    WRITE,
    DONE
  } sys_resp_state_t;

  localparam int         SYS_BURSTLEN  = 4;
  localparam logic       SYSRW_READ    = 1'b1;
  localparam logic       SYSRW_WRITE   = 1'b0;
  localparam logic [3:0] MEM_WEB_IDLE  = 4'hF;
  localparam logic [3:0] MEM_WEB_WRITE = 4'h0;

endpackage

// File: rtl/sys_beat_counter.sv
// Loadable down-counter used for the access latency and then for the remaining burst beats.
module sys_beat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // Saturates at zero so a stray decrement never wraps to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sys_mem_responder.sv
// System-bus responder: 4-word read bursts and single-word writes to a synchronous SRAM.
// Define SYS_RESP_WRAP_EN for critical-word-first burst order; otherwise bursts start at offset 0.
module sys_mem_responder
  import sys_bus_pkg::*;
#(
  parameter int ADDRWIDTH    = 32,
  parameter int DATAWIDTH    = 32,
  parameter int MEMADDRWIDTH = 14,
  parameter int LATENCY      = 2,
  parameter int BURSTLEN     = SYS_BURSTLEN
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    SYSstrobe,
  input  logic                    SYSrw,
  input  logic [ADDRWIDTH-1:0]    SYSaddr,
  input  logic [DATAWIDTH-1:0]    SYSwdata,
  output logic                    SYSready,
  output logic [DATAWIDTH-1:0]    SYSrdata,
  output logic                    mem_cs,
  output logic                    mem_oe,
  output logic [3:0]              mem_web,
  output logic [MEMADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0]    mem_di,
  input  logic [DATAWIDTH-1:0]    mem_do
);

  localparam logic [3:0] LAT_LOAD  = 4'(LATENCY);
  localparam logic [3:0] LAST_BEAT = 4'(BURSTLEN - 1);

  sys_resp_state_t         state_q;
  logic [MEMADDRWIDTH-1:0] addr_q;
  logic                    rw_q;
  logic [DATAWIDTH-1:0]    wdata_q;
  logic                    ready_q;
  logic                    rd_valid_q;
  logic                    cs_q;
  logic                    oe_q;
  logic [3:0]              web_q;
  logic [MEMADDRWIDTH-1:0] maddr_q;
  logic [DATAWIDTH-1:0]    di_q;

  logic [MEMADDRWIDTH-1:0] req_word;
  logic                    req_rw;
  logic [DATAWIDTH-1:0]    req_wdata;
  logic [1:0]              start_off;
  logic [MEMADDRWIDTH-1:0] first_beat;
  logic [MEMADDRWIDTH-1:0] next_beat;
  logic                    go_issue;
  logic                    cnt_load;
  logic [3:0]              cnt_val;
  logic                    cnt_dec;
  logic [3:0]              cnt_count;
  logic                    cnt_zero;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^{SYSaddr[ADDRWIDTH-1:MEMADDRWIDTH+2], SYSaddr[1:0]};

  // With zero latency the access is issued straight from IDLE, so use the live bus fields.
  assign req_word  = (state_q == IDLE) ? SYSaddr[MEMADDRWIDTH+1:2] : addr_q;
  assign req_rw    = (state_q == IDLE) ? SYSrw : rw_q;
  assign req_wdata = (state_q == IDLE) ? SYSwdata : wdata_q;

`ifdef SYS_RESP_WRAP_EN
  assign start_off = req_word[1:0];
`else
  assign start_off = 2'b00;
`endif

  assign first_beat = {req_word[MEMADDRWIDTH-1:2], start_off};
  assign next_beat  = {maddr_q[MEMADDRWIDTH-1:2], maddr_q[1:0] + 2'd1};

  assign go_issue = SYSstrobe &&
                    (((state_q == IDLE) && (LATENCY == 0)) ||
                     ((state_q == WAIT) && (cnt_count == 4'd1)));

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = LAT_LOAD;
    cnt_dec  = 1'b0;
    if (go_issue) begin
      cnt_load = (req_rw == SYSRW_READ);
      cnt_val  = LAST_BEAT;
    end else if ((state_q == IDLE) && SYSstrobe) begin
      cnt_load = 1'b1;
    end
    if (SYSstrobe && !go_issue) begin
      cnt_dec = (state_q == WAIT) || ((state_q == RDISSUE) && !cnt_zero);
    end
  end

  sys_beat_counter #(.WIDTH(4)) u_beat_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_count),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rw_q       <= SYSRW_WRITE;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      cs_q       <= 1'b0;
      oe_q       <= 1'b0;
      web_q      <= MEM_WEB_IDLE;
      maddr_q    <= '0;
      di_q       <= '0;
    end else begin
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (SYSstrobe) begin
            addr_q  <= SYSaddr[MEMADDRWIDTH+1:2];
            rw_q    <= SYSrw;
            wdata_q <= SYSwdata;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!SYSstrobe) state_q <= IDLE;
        end
        RDISSUE: begin
          if (!SYSstrobe) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
          end else begin
            // Data for the beat issued this cycle appears on mem_do next cycle.
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b1;
            if (cnt_zero) begin
              state_q <= RDLAST;
              cs_q    <= 1'b0;
              oe_q    <= 1'b0;
            end else begin
              maddr_q <= next_beat;
            end
          end
        end
        RDLAST: begin
          state_q <= SYSstrobe ? DONE : IDLE;
        end
        WRITE: begin
          state_q <= DONE;
          cs_q    <= 1'b0;
          web_q   <= MEM_WEB_IDLE;
        end
        DONE: begin
          if (!SYSstrobe) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (go_issue) begin
        cs_q <= 1'b1;
        if (req_rw == SYSRW_READ) begin
          state_q <= RDISSUE;
          oe_q    <= 1'b1;
          maddr_q <= first_beat;
        end else begin
          state_q <= WRITE;
          web_q   <= MEM_WEB_WRITE;
          maddr_q <= req_word;
          di_q    <= req_wdata;
          ready_q <= 1'b1;
        end
      end
    end
  end

  // The SRAM output register is the data stage; gating keeps SYSrdata at 0 between beats.
  assign SYSready = ready_q;
  assign SYSrdata = rd_valid_q ? mem_do : '0;
  assign mem_cs   = cs_q;
  assign mem_oe   = oe_q;
  assign mem_web  = web_q;
  assign mem_addr = maddr_q;
  assign mem_di   = di_q;

endmodule
